// File: rtl/systolic_row_feeder.sv
// Row feeder for the GF(2) systemizer array: accepts rows, skews them diagonally onto N
// column streams with start/finish tags. Optional bubble counter: SYSTOLIC_FEEDER_UNDERRUN_CNT_EN.
module systolic_row_feeder #(
  parameter int N    = 8,
  parameter int ROWS = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [N-1:0] row_in,
  input  logic         row_valid,
  output logic         row_ready,
  output logic [N-1:0] data_out,
  output logic [N-1:0] start_out,
  output logic [N-1:0] finish_out,
  output logic         busy,
  output logic         done,
  output logic         underrun
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]  underrun_cnt
`endif
);

  localparam int RW = $clog2(ROWS + 1);
  localparam int PW = $clog2(N + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(N - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_FLUSH  = 3'd4;

  logic [2:0]    r_state;
  logic [RW-1:0] r_row_cnt;
  logic [PW-1:0] r_phase;
  logic          r_done;
  logic          r_underrun;

  logic          w_hs;
  logic [N-1:0]  w_v_data;
  logic          w_v_start;
  logic          w_v_finish;

  assign row_ready = (r_state == S_LOAD) || (r_state == S_STREAM);
  assign w_hs      = row_valid && row_ready;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign underrun  = r_underrun;

  // Unskewed vector for this cycle; bubbles and idle cycles are all-zero.
  always_comb begin
    w_v_data   = '0;
    w_v_start  = 1'b0;
    w_v_finish = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_hs) begin
          w_v_data  = row_in;
          w_v_start = 1'b1;
        end
      end
      S_STREAM: if (w_hs) w_v_data = row_in;
      S_DRAIN:  w_v_finish = 1'b1;
      default:  ;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row_cnt  <= '0;
      r_phase    <= '0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_state    <= S_LOAD;
            r_underrun <= 1'b0;
            r_row_cnt  <= '0;
            r_phase    <= '0;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            r_row_cnt <= RW'(1);
            r_state   <= (ROWS == 1) ? S_DRAIN : S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_hs) begin
            r_row_cnt <= r_row_cnt + RW'(1);
            if (r_row_cnt == ROW_LAST) r_state <= S_DRAIN;
          end else begin
            r_underrun <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            r_state <= S_FLUSH;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        S_FLUSH: begin
          if (r_phase == PH_LAST) begin
            r_phase <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;
  assign underrun_cnt = r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (r_state == S_IDLE && go) begin
      r_underrun_cnt <= '0;
    end else if (r_state == S_STREAM && !w_hs && r_underrun_cnt != 16'hFFFF) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end
`endif

  // Column j is a (1+j)-deep shift register of {data, start, finish}.
  for (genvar j = 0; j < N; j++) begin : g_col
    logic [2:0] r_pipe [0:j];

    // NOTE: the skew flops are few and must come up clean after an abort, so they are reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k <= j; k++) r_pipe[k] <= '0;
      end else begin
        r_pipe[0] <= {w_v_data[j], w_v_start, w_v_finish};
        for (int k = 1; k <= j; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign data_out[j]   = r_pipe[j][2];
    assign start_out[j]  = r_pipe[j][1];
    assign finish_out[j] = r_pipe[j][0];
  end

endmodule
